// File: rtl/vga_pattern_gen_if.sv
// Control and video bundle between a pattern controller (master) and the
// VGA pattern generator (slave).
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 2,
    parameter int FRAME_BITS = 9
);
    logic [1:0]            mode;
    logic [2:0]            speed;
    logic                  pause;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
    logic                  hsync;
    logic                  vsync;
    logic                  display_on;
    logic                  frame_start;
    logic [FRAME_BITS-1:0] frame_no;

    modport master (
        output mode, speed, pause,
        input  r, g, b, hsync, vsync, display_on, frame_start, frame_no
    );

    modport slave (
        input  mode, speed, pause,
        output r, g, b, hsync, vsync, display_on, frame_start, frame_no
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern engine: raster timing, frame counter and four animated
// patterns. Mode/speed are latched only at the first blank line so a frame
// never mixes patterns. All video outputs leave through one register stage.
module vga_pattern_gen #(
    parameter int H_DISPLAY        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_DISPLAY        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int COLOR_BITS       = 2,
    parameter int FRAME_BITS       = 9,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_pattern_gen_if.slave bus
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // Counters are at least 10 bits wide so pattern bit picks stay legal
    // even for tiny timing sets.
    localparam int HW       = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW       = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
    localparam int C        = COLOR_BITS;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;

    localparam logic                  SYNC_IDLE = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;
    localparam logic [C-1:0]          ONES      = {C{1'b1}};
    localparam logic [C-1:0]          ZERO      = {C{1'b0}};
    localparam logic [FRAME_BITS-1:0] STEP_ONE  = {{(FRAME_BITS-1){1'b0}}, 1'b1};

    logic [HW-1:0]         r_hpos;
    logic [VW-1:0]         r_vpos;
    logic [1:0]            r_mode;
    logic [FRAME_BITS-1:0] r_step;
    logic [FRAME_BITS-1:0] r_frame_no;
    logic [C-1:0]          r_r;
    logic [C-1:0]          r_g;
    logic [C-1:0]          r_b;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_display_on;
    logic                  r_frame_start;

    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_visible;
    logic                  w_hsync_act;
    logic                  w_vsync_act;
    logic                  w_frame_evt;
    logic                  w_chk;
    logic                  w_x_carry;
    logic [2:0]            w_x_hi;
    logic [2:0]            w_bar;
    logic [C-1:0]          w_sb_r;
    logic [C-1:0]          w_sb_g;
    logic [C-1:0]          w_sb_b;
    logic [C-1:0]          w_r;
    logic [C-1:0]          w_g;
    logic [C-1:0]          w_b;

    assign w_h_last    = (r_hpos == HW'(H_TOTAL - 1));
    assign w_v_last    = (r_vpos == VW'(V_TOTAL - 1));
    assign w_visible   = (r_hpos < HW'(H_DISPLAY)) && (r_vpos < VW'(V_DISPLAY));
    assign w_hsync_act = (r_hpos >= HW'(HS_START)) && (r_hpos <= HW'(HS_END));
    assign w_vsync_act = (r_vpos >= VW'(VS_START)) && (r_vpos <= VW'(VS_END));
    assign w_frame_evt = (r_hpos == HW'(0)) && (r_vpos == VW'(V_DISPLAY));

    // Checker: 32-pixel squares, inverted every 64 frames.
    assign w_chk = r_hpos[5] ^ r_vpos[5] ^ r_frame_no[6];

    // Scroll coordinate x = hpos + frame_no; only x[7:5] is displayed, so the
    // low five bits contribute just their carry.
    assign w_x_carry = (6'(r_hpos[4:0]) + 6'(r_frame_no[4:0])) > 6'd31;
    assign w_x_hi    = r_hpos[7:5] + r_frame_no[7:5] + {2'b00, w_x_carry};

    generate
        if (C == 1) begin : g_bars_1bit
            assign w_sb_r = w_x_hi[0];
            assign w_sb_g = w_x_hi[1];
            assign w_sb_b = w_x_hi[2];
        end else begin : g_bars_nbit
            assign w_sb_r = {w_x_hi[0], r_vpos[2 +: C-1]};
            assign w_sb_g = {w_x_hi[1], r_vpos[2 +: C-1]};
            assign w_sb_b = {w_x_hi[2], r_vpos[5 +: C-1]};
        end
    endgenerate

    // Colour-bar index: count of bar thresholds already passed (no divider).
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            w_bar = w_bar + ((r_hpos >= HW'((k * H_DISPLAY + 7) / 8)) ? 3'd1 : 3'd0);
        end
    end

    // Pattern select; colours are blanked outside the visible area.
    always_comb begin
        w_r = ZERO;
        w_g = ZERO;
        w_b = ZERO;
        if (w_visible) begin
            case (r_mode)
                2'd0: begin
                    w_r = w_chk ? ONES : ZERO;
                    w_g = w_chk ? ONES : ZERO;
                    w_b = w_chk ? ONES : ZERO;
                end
                2'd1: begin
                    w_r = w_sb_r;
                    w_g = w_sb_g;
                    w_b = w_sb_b;
                end
                2'd2: begin
                    w_r = r_hpos[9 -: C];
                    w_g = r_vpos[8 -: C];
                    w_b = r_hpos[9 -: C] + r_frame_no[7 -: C];
                end
                2'd3: begin
                    w_r = w_bar[2] ? ONES : ZERO;
                    w_g = w_bar[1] ? ONES : ZERO;
                    w_b = w_bar[0] ? ONES : ZERO;
                end
                default: begin
                    w_r = ZERO;
                    w_g = ZERO;
                    w_b = ZERO;
                end
            endcase
        end else begin
            w_r = ZERO;
            w_g = ZERO;
            w_b = ZERO;
        end
    end

    // Raster position: hpos sweeps each line, vpos steps on every hpos wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hpos <= HW'(0);
            r_vpos <= VW'(0);
        end else if (w_h_last) begin
            r_hpos <= HW'(0);
            r_vpos <= w_v_last ? VW'(0) : r_vpos + VW'(1);
        end else begin
            r_hpos <= r_hpos + HW'(1);
        end
    end

    // Frame boundary: latch mode/speed and advance frame_no by the old step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode     <= 2'd0;
            r_step     <= STEP_ONE;
            r_frame_no <= {FRAME_BITS{1'b0}};
        end else if (w_frame_evt) begin
            r_mode <= bus.mode;
            r_step <= STEP_ONE << bus.speed;
            if (!bus.pause) begin
                r_frame_no <= r_frame_no + r_step;
            end
        end
    end

    // Single output stage keeping colours, syncs and flags mutually aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r           <= ZERO;
            r_g           <= ZERO;
            r_b           <= ZERO;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_display_on  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            r_hsync       <= w_hsync_act ? ~SYNC_IDLE : SYNC_IDLE;
            r_vsync       <= w_vsync_act ? ~SYNC_IDLE : SYNC_IDLE;
            r_display_on  <= w_visible;
            r_frame_start <= w_frame_evt;
        end
    end

    assign bus.r           = r_r;
    assign bus.g           = r_g;
    assign bus.b           = r_b;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.display_on  = r_display_on;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_no    = r_frame_no;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: DUT A uses full-width lines (800 clk) with a short frame,
// DUT B uses tiny timing, 1-bit colour and active-high syncs. The bench keeps
// its own raster position for each DUT; outputs lag that position by 1 clk.
module tb_vga_pattern_gen;
    localparam int A_HT = 800;
    localparam int A_VT = 12;
    localparam int B_HT = 24;
    localparam int B_VT = 12;

    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    int   checks;
    int   errors;
    int   ha, va, hb, vb;
    int   cnt;
    int   n;

    int spd[14]  = '{0, 0, 0, 3, 7, 7, 7, 6, 5, 4, 1, 0, 0, 0};
    int expf[14] = '{1, 2, 3, 4, 12, 140, 268, 396, 460, 492, 508, 510, 511, 0};

    vga_pattern_gen_if #(.COLOR_BITS(2), .FRAME_BITS(9)) ifa ();
    vga_pattern_gen_if #(.COLOR_BITS(1), .FRAME_BITS(9)) ifb ();

    vga_pattern_gen #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .COLOR_BITS(2), .FRAME_BITS(9), .SYNC_ACTIVE_HIGH(0)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_a_n),
        .bus  (ifa)
    );

    vga_pattern_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .COLOR_BITS(1), .FRAME_BITS(9), .SYNC_ACTIVE_HIGH(1)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_b_n),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference raster positions (the pixel each DUT is currently working on).
    always @(posedge clk) begin
        if (!rst_a_n) begin
            ha <= 0;
            va <= 0;
        end else if (ha == A_HT - 1) begin
            ha <= 0;
            va <= (va == A_VT - 1) ? 0 : va + 1;
        end else begin
            ha <= ha + 1;
        end
    end

    // Reference raster position for DUT B.
    always @(posedge clk) begin
        if (!rst_b_n) begin
            hb <= 0;
            vb <= 0;
        end else if (hb == B_HT - 1) begin
            hb <= 0;
            vb <= (vb == B_VT - 1) ? 0 : vb + 1;
        end else begin
            hb <= hb + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_a(input int h, input int v);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(ha == h && va == v) && k < 20000);
        if (!(ha == h && va == v)) timeout("wait_a");
    endtask

    task automatic wait_b(input int h, input int v);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(hb == h && vb == v) && k < 1000);
        if (!(hb == h && vb == v)) timeout("wait_b");
    endtask

    task automatic wait_fs_b();
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (ifb.frame_start !== 1'b1 && k < 1000);
        if (ifb.frame_start !== 1'b1) timeout("wait_fs_b");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_a_n   = 1'b0;
        rst_b_n   = 1'b0;
        ifa.mode  = 2'd0;
        ifa.speed = 3'd0;
        ifa.pause = 1'b0;
        ifb.mode  = 2'd0;
        ifb.speed = 3'd0;
        ifb.pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        chk("a_rst_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        chk("a_rst_hsync", 32'(ifa.hsync), 32'h1);
        chk("a_rst_vsync", 32'(ifa.vsync), 32'h1);
        chk("a_rst_disp", 32'(ifa.display_on), 32'h0);
        chk("a_rst_fs", 32'(ifa.frame_start), 32'h0);
        chk("a_rst_fno", 32'(ifa.frame_no), 32'h0);
        chk("b_rst_hsync", 32'(ifb.hsync), 32'h0);
        chk("b_rst_vsync", 32'(ifb.vsync), 32'h0);
        rst_a_n = 1'b1;

        // Frame 0, checker, first pixel and alignment.
        wait_a(1, 0);
        chk("a_disp_rise", 32'(ifa.display_on), 32'h1);
        chk("a_px00", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        wait_a(33, 0);
        chk("a_checker", 32'({ifa.r, ifa.g, ifa.b}), 32'h3F);

        // Horizontal sync window edges and width.
        wait_a(656, 0);
        chk("a_hs_before", 32'(ifa.hsync), 32'h1);
        wait_a(657, 0);
        chk("a_hs_first", 32'(ifa.hsync), 32'h0);
        wait_a(752, 0);
        chk("a_hs_last", 32'(ifa.hsync), 32'h0);
        wait_a(753, 0);
        chk("a_hs_after", 32'(ifa.hsync), 32'h1);
        wait_a(0, 1);
        cnt = 0;
        repeat (A_HT) begin
            if (ifa.hsync === 1'b0) cnt++;
            @(posedge clk);
            #1;
        end
        chk("a_hs_width", 32'(cnt), 32'd96);

        // Blanked colour where the checker would be lit.
        wait_a(673, 2);
        chk("a_blank_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        chk("a_blank_disp", 32'(ifa.display_on), 32'h0);

        // Mode change mid-frame is held until the frame event.
        ifa.mode = 2'd3;
        wait_a(33, 3);
        chk("a_mode_hold", 32'({ifa.r, ifa.g, ifa.b}), 32'h3F);
        wait_a(1, 8);
        chk("a_fs_pulse", 32'(ifa.frame_start), 32'h1);
        chk("a_fno_1", 32'(ifa.frame_no), 32'd1);
        wait_a(2, 8);
        chk("a_fs_end", 32'(ifa.frame_start), 32'h0);

        // Vertical sync width: lines 9 and 10, until the frame wraps.
        cnt = 0;
        n   = 0;
        do begin
            if (ifa.vsync === 1'b0) cnt++;
            @(posedge clk);
            #1;
            n++;
        end while (!(ha == 0 && va == 0) && n < 20000);
        chk("a_vs_width", 32'(cnt), 32'd1600);

        // Frame 1, colour bars.
        wait_a(1, 0);
        chk("a_bar_px0", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        wait_a(80, 0);
        chk("a_bar_79", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        wait_a(81, 0);
        chk("a_bar_80", 32'({ifa.r, ifa.g, ifa.b}), 32'h03);
        wait_a(561, 0);
        chk("a_bar_560", 32'({ifa.r, ifa.g, ifa.b}), 32'h3F);
        wait_a(641, 0);
        chk("a_bar_640", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);

        // Frame 2, gradient.
        ifa.mode = 2'd2;
        wait_a(1, 8);
        chk("a_fno_2", 32'(ifa.frame_no), 32'd2);
        wait_a(301, 0);
        chk("a_grad_300", 32'({ifa.r, ifa.g, ifa.b}), 32'h11);
        wait_a(601, 0);
        chk("a_grad_600", 32'({ifa.r, ifa.g, ifa.b}), 32'h22);

        // Frame 3, scrolling bars (x = hpos + 3).
        ifa.mode = 2'd1;
        wait_a(1, 8);
        chk("a_fno_3", 32'(ifa.frame_no), 32'd3);
        wait_a(94, 0);
        chk("a_scroll_v0", 32'({ifa.r, ifa.g, ifa.b}), 32'h28);
        wait_a(94, 4);
        chk("a_scroll_v4", 32'({ifa.r, ifa.g, ifa.b}), 32'h3C);

        // Mid-frame reset for one clock.
        wait_a(100, 5);
        rst_a_n = 1'b0;
        @(posedge clk);
        #1;
        chk("a_mrst_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        chk("a_mrst_disp", 32'(ifa.display_on), 32'h0);
        chk("a_mrst_hs", 32'(ifa.hsync), 32'h1);
        chk("a_mrst_vs", 32'(ifa.vsync), 32'h1);
        chk("a_mrst_fno", 32'(ifa.frame_no), 32'h0);
        rst_a_n = 1'b1;
        wait_a(1, 0);
        chk("a_mrst_restart", 32'(ifa.display_on), 32'h1);
        wait_a(33, 0);
        chk("a_mrst_mode0", 32'({ifa.r, ifa.g, ifa.b}), 32'h3F);

        // DUT B: frame counter steps, wrap and checker inversion.
        rst_b_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            ifb.speed = 3'(spd[k]);
            wait_fs_b();
            chk("b_fs_pos", 32'(hb * 32 + vb), 32'd40);
            chk("b_fno", 32'(ifb.frame_no), 32'(expf[k]));
            @(posedge clk);
            #1;
            chk("b_fs_width", 32'(ifb.frame_start), 32'h0);
            wait_b(1, 0);
            chk("b_checker", 32'({ifb.r, ifb.g, ifb.b}), expf[k][6] ? 32'd7 : 32'd0);
        end

        // Pause holds the counter; mode still switches at the boundary only.
        ifb.pause = 1'b1;
        wait_b(0, 4);
        ifb.mode = 2'd3;
        wait_b(16, 5);
        chk("b_mode_hold", 32'({ifb.r, ifb.g, ifb.b}), 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_fs_b();
            chk("b_pause_fno", 32'(ifb.frame_no), 32'h0);
        end
        wait_b(16, 0);
        chk("b_bars_next", 32'({ifb.r, ifb.g, ifb.b}), 32'h7);

        // Active-high sync widths on the small timing set.
        wait_b(0, 1);
        cnt = 0;
        repeat (B_HT) begin
            if (ifb.hsync === 1'b1) cnt++;
            @(posedge clk);
            #1;
        end
        chk("b_hs_width", 32'(cnt), 32'd4);
        cnt = 0;
        repeat (B_HT * B_VT) begin
            if (ifb.vsync === 1'b1) cnt++;
            @(posedge clk);
            #1;
        end
        chk("b_vs_width", 32'(cnt), 32'd48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
